// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing defaults and status-flag decode
package fifo_pkg;
  localparam int DATA_WIDTH_DEF = 10;
  localparam int ADDR_SIZE_DEF = 3;
  localparam int ALMOST_FULL_TH_DEF = 6;
  localparam int ALMOST_EMPTY_TH_DEF = 2;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;
  function automatic fifo_flags_t decode_flags(input int count, input int depth, input int af_th, input int ae_th);
    fifo_flags_t f;
    f.full = count == depth;
    f.empty = count == 0;
    f.almost_full = count >= af_th;
    f.almost_empty = count <= ae_th;
    return f;
  endfunction
endpackage

// File: rtl/memoria_dp.sv
// memoria_dp: dual-port register RAM, sync write, registered sync read
module memoria_dp #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_SIZE = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [ADDR_SIZE-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_SIZE];
  // storage is deliberately left unreset; only the read register clears
  always_ff @(posedge clk)
    if (wr_enb) mem[wr_addr] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) data_out <= '0;
    else if (rd_enb) data_out <= mem[rd_addr];
endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with thresholds and sticky error flags
module fifo_param import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int ALMOST_FULL_TH = ALMOST_FULL_TH_DEF,
  parameter int ALMOST_EMPTY_TH = ALMOST_EMPTY_TH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_enb,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_SIZE:0]    fill_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  logic [ADDR_SIZE-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc;
  fifo_flags_t flags;
  // a read on a full FIFO frees the slot the simultaneous write reuses
  assign rd_acc = rd_enb && !empty;
  assign wr_acc = wr_enb && (!full || rd_acc);
  always_comb flags = decode_flags(int'(fill_count), DEPTH, ALMOST_FULL_TH, ALMOST_EMPTY_TH);
  assign full = flags.full;
  assign empty = flags.empty;
  assign almost_full = flags.almost_full;
  assign almost_empty = flags.almost_empty;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_count <= '0;
      valid_out <= 1'b0;
      overflow_err <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_SIZE'(wr_acc);
      rd_ptr <= rd_ptr + ADDR_SIZE'(rd_acc);
      fill_count <= fill_count + (ADDR_SIZE+1)'(wr_acc) - (ADDR_SIZE+1)'(rd_acc);
      valid_out <= rd_acc;
      overflow_err <= overflow_err || (wr_enb && !wr_acc);
      underflow_err <= underflow_err || (rd_enb && empty);
    end
  memoria_dp #(.DATA_WIDTH(DATA_WIDTH), .ADDR_SIZE(ADDR_SIZE)) u_mem (
    .clk(clk),
    .rst(rst),
    .wr_enb(wr_acc),
    .wr_addr(wr_ptr),
    .data_in(data_in),
    .rd_enb(rd_acc),
    .rd_addr(rd_ptr),
    .data_out(data_out)
  );
endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed vector table, corner sequences and random queue-model check
module tb_fifo_param;
  logic clk = 0, rst = 0, wr_enb = 0, rd_enb = 0;
  logic [9:0] data_in = '0, data_out;
  logic valid_out, full, empty, almost_full, almost_empty, overflow_err, underflow_err;
  logic [3:0] fill_count;
  int checks = 0, errors = 0;

  typedef struct {
    logic r, w, rd;
    logic [9:0] din, dout;
    logic valid;
    int cnt;
    logic ovf, udf;
  } vec_t;
  vec_t vecs[$];

  fifo_param dut (
    .clk(clk), .rst(rst), .wr_enb(wr_enb), .data_in(data_in), .rd_enb(rd_enb),
    .data_out(data_out), .valid_out(valid_out), .fill_count(fill_count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input int dout, input int valid, input int cnt, input int ovf, input int udf);
    chk({tag, "_dout"}, int'(data_out), dout);
    chk({tag, "_valid"}, int'(valid_out), valid);
    chk({tag, "_count"}, int'(fill_count), cnt);
    chk({tag, "_flags"}, int'({full, empty, almost_full, almost_empty}),
        int'({cnt == 8, cnt == 0, cnt >= 6, cnt <= 2}));
    chk({tag, "_errs"}, int'({overflow_err, underflow_err}), int'({ovf[0], udf[0]}));
  endtask

  task automatic step(input logic r, input logic w, input logic rd, input logic [9:0] d);
    rst = r; wr_enb = w; rd_enb = rd; data_in = d;
    @(posedge clk);
    #1;
    rst = 0; wr_enb = 0; rd_enb = 0;
  endtask

  function automatic void add(input logic r, w, rd, input logic [9:0] din, dout, input logic valid,
                              input int cnt, input logic ovf, udf);
    vec_t v;
    v.r = r; v.w = w; v.rd = rd; v.din = din; v.dout = dout;
    v.valid = valid; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endfunction

  initial begin
    int q[$];
    int exp_dout, exp_valid, ovf_m, udf_m;
    // reset state, asserted asynchronously before any clock edge
    rst = 1;
    #1;
    chk_state("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 0;

    // directed vector table
    add(0, 0, 1, 10'h000, 10'h000, 0, 0, 0, 1);
    add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    add(0, 1, 0, 10'h0FF, 10'h000, 0, 1, 0, 0);
    add(0, 1, 0, 10'h0CC, 10'h000, 0, 2, 0, 0);
    add(0, 1, 0, 10'h00A, 10'h000, 0, 3, 0, 0);
    add(0, 0, 1, 10'h000, 10'h0FF, 1, 2, 0, 0);
    add(0, 0, 1, 10'h000, 10'h0CC, 1, 1, 0, 0);
    add(0, 0, 1, 10'h000, 10'h00A, 1, 0, 0, 0);
    add(0, 0, 0, 10'h000, 10'h00A, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 0, 10'(i), 10'h00A, 0, i + 1, 0, 0);
    add(0, 1, 0, 10'h3FF, 10'h00A, 0, 8, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, 10'(10'h100 + i), 10'(i), 1, 8, 1, 0);
    for (int i = 0; i < 8; i++) add(0, 0, 1, 10'h000, 10'(10'h100 + i), 1, 7 - i, 1, 0);
    add(0, 0, 0, 10'h000, 10'h107, 0, 0, 1, 0);
    add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    add(0, 1, 1, 10'h2AA, 10'h000, 0, 1, 0, 1);
    add(0, 0, 1, 10'h000, 10'h2AA, 1, 0, 0, 1);
    add(1, 0, 0, 10'h000, 10'h000, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].w, vecs[i].rd, vecs[i].din);
      chk_state($sformatf("vec%0d", i), int'(vecs[i].dout), int'(vecs[i].valid),
                vecs[i].cnt, int'(vecs[i].ovf), int'(vecs[i].udf));
    end

    // reset mid-stream with count 5 and a word on data_out: clears without a clock edge
    for (int i = 0; i < 6; i++) step(0, 1, 0, 10'(10'h011 * (i + 1)));
    step(0, 0, 1, 10'h000);
    chk_state("pre_rst", 10'h011, 1, 5, 0, 0);
    rst = 1;
    #1;
    chk_state("async_rst", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 0;
    step(0, 1, 0, 10'h155);
    chk_state("post_rst_wr", 0, 0, 1, 0, 0);
    step(0, 0, 1, 10'h000);
    chk_state("post_rst_rd", 10'h155, 1, 0, 0, 0);

    // randomized traffic against a queue model
    step(1, 0, 0, 10'h000);
    exp_dout = 0; ovf_m = 0; udf_m = 0;
    for (int n = 0; n < 600; n++) begin
      int bias, w, r, d, rd_ok, wr_ok;
      bias = (n / 100) % 2 == 0 ? 75 : 30;
      w = ($urandom % 100) < bias;
      r = ($urandom % 100) < (100 - bias);
      d = $urandom % 1024;
      rd_ok = r && q.size() > 0;
      wr_ok = w && (q.size() < 8 || rd_ok);
      if (r && q.size() == 0) udf_m = 1;
      if (w && !wr_ok) ovf_m = 1;
      if (rd_ok) exp_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      exp_valid = rd_ok;
      step(0, w[0], r[0], 10'(d));
      chk_state($sformatf("rnd%0d", n), exp_dout, exp_valid, q.size(), ovf_m, udf_m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
